// File: rtl/frame_sched_ctrl_pkg.sv
// Shared constants, state encoding and result record for the LeNet frame path.
// Imported by the scheduler interface, top and bench.
package lenet_pipe_pkg;

  localparam int OUT_W     = 32;
  localparam int OUT_H_PAD = 32;
  localparam int FRAME_PIX = OUT_W * OUT_H_PAD;

  localparam int TAG_W = 4;
  localparam int CLS_W = 4;
  localparam int PC_W  = 11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SWAP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_KICK = 3'd3;
  localparam logic [2:0] S_CNN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    SWAP = S_SWAP,
    RUN  = S_RUN,
    KICK = S_KICK,
    CNN  = S_CNN
  } state_t;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [TAG_W-1:0] tag;
  } result_t;

  function automatic logic [PC_W-1:0] pc_sat_inc(input logic [PC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_sched_ctrl_if.sv
// Signal bundle between the frame scheduler and its neighbours (camera writer,
// core reader, CNN engine). slave = scheduler side, master = environment side.
interface frame_sched_ctrl_if #(
  parameter int CW = 16
);
  import lenet_pipe_pkg::*;

  logic             wr_frame_done;
  logic [TAG_W-1:0] image_num_in;
  logic             q_valid;
  logic             q_frame_last;
  logic             cnn_ready;
  logic             cnn_done;
  logic [CLS_W-1:0] cnn_class;

  logic             wr_bank;
  logic             rd_bank;
  logic             core_start;
  logic [TAG_W-1:0] image_num_core;
  logic             cnn_start;
  logic             result_valid;
  logic [CLS_W-1:0] result_class;
  logic [TAG_W-1:0] result_tag;
  logic             busy;
  logic [CW-1:0]    frame_cnt;
  logic [CW-1:0]    drop_cnt;
  logic             len_err;
  logic             wdog_err;

  modport slave (
    input  wr_frame_done, image_num_in, q_valid, q_frame_last,
           cnn_ready, cnn_done, cnn_class,
    output wr_bank, rd_bank, core_start, image_num_core, cnn_start,
           result_valid, result_class, result_tag, busy,
           frame_cnt, drop_cnt, len_err, wdog_err
  );

  modport master (
    output wr_frame_done, image_num_in, q_valid, q_frame_last,
           cnn_ready, cnn_done, cnn_class,
    input  wr_bank, rd_bank, core_start, image_num_core, cnn_start,
           result_valid, result_class, result_tag, busy,
           frame_cnt, drop_cnt, len_err, wdog_err
  );

endinterface

// File: rtl/frame_sched_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_sched_ctrl.sv
// Frame scheduler: ping-pong bank select, core/CNN start sequencing, result latch.
// Optional RUN/CNN watchdog is built only when FRAME_SCHED_WDOG_EN is defined.
module frame_sched_ctrl #(
  parameter int FRAME_PIX = lenet_pipe_pkg::FRAME_PIX,
  parameter int FRAME_DIV = 1,
  parameter int CW        = 16,
  parameter int WDOG_CYC  = 400000
) (
  input  logic              clk,
  input  logic              srst,
  frame_sched_ctrl_if.slave bus
);
  import lenet_pipe_pkg::*;

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic [PC_W:0] PIX_TARGET = (PC_W + 1)'(FRAME_PIX);

  if ((FRAME_DIV < 1) || (WDOG_CYC < 1)) begin : g_param_check
    $error("frame_sched_ctrl: FRAME_DIV and WDOG_CYC must be >= 1");
  end

  state_t           state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             core_start_q, core_start_d;
  logic             cnn_start_q, cnn_start_d;
  logic             result_valid_q, result_valid_d;
  result_t          result_q, result_d;
  logic [TAG_W-1:0] image_num_q, image_num_d;
  logic             len_err_q, len_err_d;
  logic             wdog_err_q, wdog_err_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    div_q, div_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             frame_inc;
  logic             drop_inc;
  logic             wd_fire;
  logic [CW-1:0]    frame_cnt;
  logic [CW-1:0]    drop_cnt;

`ifdef FRAME_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic          in_wd_state;
  logic [WW-1:0] wd_cnt;

  // Cleared in every other state, so entering RUN or CNN always starts from zero.
  assign in_wd_state = (state_q == RUN) || (state_q == CNN);

  sat_counter #(.W(WW)) u_wdog_cnt (
    .clk   (clk),
    .srst  (srst),
    .clear (!in_wd_state),
    .inc   (in_wd_state),
    .count (wd_cnt)
  );

  assign wd_fire = in_wd_state && (wd_cnt == WW'(WDOG_CYC - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    core_start_d   = 1'b0;
    cnn_start_d    = 1'b0;
    result_valid_d = 1'b0;
    result_d       = result_q;
    image_num_d    = image_num_q;
    len_err_d      = len_err_q;
    wdog_err_d     = wdog_err_q;
    div_d          = div_q;
    pc_d           = pc_q;
    frame_inc      = 1'b0;
    drop_inc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.wr_frame_done) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bus.cnn_ready) begin
              wr_bank_d   = ~wr_bank_q;
              rd_bank_d   = wr_bank_q;
              image_num_d = bus.image_num_in;
              state_d     = SWAP;
            end else begin
              drop_inc = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      // core_start is registered here, so it appears two clocks after wr_frame_done.
      SWAP: begin
        core_start_d = 1'b1;
        pc_d         = '0;
        state_d      = RUN;
      end
      RUN: begin
        if (bus.q_valid) begin
          pc_d = pc_sat_inc(pc_q);
          if (bus.q_frame_last) begin
            if (({1'b0, pc_q} + 1'b1) != PIX_TARGET) begin
              len_err_d = 1'b1;
            end
            cnn_start_d = 1'b1;
            state_d     = KICK;
          end
        end
        if ((state_d == RUN) && wd_fire) begin
          wdog_err_d = 1'b1;
          drop_inc   = 1'b1;
          state_d    = IDLE;
        end
      end
      KICK: begin
        state_d = CNN;
      end
      CNN: begin
        if (bus.cnn_done) begin
          result_d.cls   = bus.cnn_class;
          result_d.tag   = image_num_q;
          result_valid_d = 1'b1;
          frame_inc      = 1'b1;
          state_d        = IDLE;
        end else if (wd_fire) begin
          wdog_err_d = 1'b1;
          drop_inc   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The writer keeps its bank whenever we are not idle, so the frame is lost.
    if (bus.wr_frame_done && (state_q != IDLE)) begin
      drop_inc = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q        <= IDLE;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      core_start_q   <= 1'b0;
      cnn_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      image_num_q    <= '0;
      len_err_q      <= 1'b0;
      wdog_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      div_q          <= '0;
      pc_q           <= '0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      core_start_q   <= core_start_d;
      cnn_start_q    <= cnn_start_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      image_num_q    <= image_num_d;
      len_err_q      <= len_err_d;
      wdog_err_q     <= wdog_err_d;
      busy_q         <= busy_d;
      div_q          <= div_d;
      pc_q           <= pc_d;
    end
  end

  sat_counter #(.W(CW)) u_frame_cnt (
    .clk   (clk),
    .srst  (srst),
    .clear (1'b0),
    .inc   (frame_inc),
    .count (frame_cnt)
  );

  sat_counter #(.W(CW)) u_drop_cnt (
    .clk   (clk),
    .srst  (srst),
    .clear (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  assign bus.wr_bank        = wr_bank_q;
  assign bus.rd_bank        = rd_bank_q;
  assign bus.core_start     = core_start_q;
  assign bus.image_num_core = image_num_q;
  assign bus.cnn_start      = cnn_start_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_class   = result_q.cls;
  assign bus.result_tag     = result_q.tag;
  assign bus.busy           = busy_q;
  assign bus.frame_cnt      = frame_cnt;
  assign bus.drop_cnt       = drop_cnt;
  assign bus.len_err        = len_err_q;
  assign bus.wdog_err       = wdog_err_q;

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Bench for frame_sched_ctrl: dut_a (FRAME_DIV=1) for flow/length/drop/reset,
// dut_b (FRAME_DIV=3, WDOG_CYC=100) for decimation and CNN stall behaviour.
module tb_frame_sched_ctrl;
  import lenet_pipe_pkg::*;

  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst_a;
  logic srst_b;

  frame_sched_ctrl_if #(.CW(CW)) bus_a ();
  frame_sched_ctrl_if #(.CW(CW)) bus_b ();

  frame_sched_ctrl #(.FRAME_PIX(FRAME_PIX), .FRAME_DIV(1), .CW(CW), .WDOG_CYC(4000)) dut_a (
    .clk  (clk),
    .srst (srst_a),
    .bus  (bus_a)
  );

  frame_sched_ctrl #(.FRAME_PIX(FRAME_PIX), .FRAME_DIV(3), .CW(CW), .WDOG_CYC(100)) dut_b (
    .clk  (clk),
    .srst (srst_b),
    .bus  (bus_b)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  result_t exp_q[$];
  result_t mon_exp;
  int core_start_a = 0;
  int cnn_start_a  = 0;
  int result_a     = 0;
  int core_start_b = 0;
  int cnn_start_b  = 0;
  int result_b     = 0;
  int snap;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Pulse counters and result scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.core_start)  core_start_a++;
    if (bus_a.cnn_start)   cnn_start_a++;
    if (bus_b.core_start)  core_start_b++;
    if (bus_b.cnn_start)   cnn_start_b++;
    if (bus_b.result_valid) result_b++;
    if (bus_a.result_valid) begin
      result_a++;
      if (exp_q.size() == 0) begin
        checkOutput("result_unexpected", bus_a.result_valid, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("sb_result_class", bus_a.result_class, mon_exp.cls);
        checkOutput("sb_result_tag", bus_a.result_tag, mon_exp.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wfd, input logic [3:0] tag, input logic qv,
                               input logic last, input logic done, input logic [3:0] cls);
    bus_a.wr_frame_done = wfd;
    bus_a.image_num_in  = tag;
    bus_a.q_valid       = qv;
    bus_a.q_frame_last  = last;
    bus_a.cnn_done      = done;
    bus_a.cnn_class     = cls;
    tick();
    bus_a.wr_frame_done = 1'b0;
    bus_a.q_valid       = 1'b0;
    bus_a.q_frame_last  = 1'b0;
    bus_a.cnn_done      = 1'b0;
  endtask

  task automatic resetA();
    srst_a = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    srst_a = 1'b0;
  endtask

  task automatic startFrame(input logic [3:0] tag, input logic exp_wr_bank);
    applyStimulus(1, tag, 0, 0, 0, 0);
    checkOutput("swap_wr_bank", bus_a.wr_bank, exp_wr_bank);
    checkOutput("swap_rd_bank", bus_a.rd_bank, !exp_wr_bank);
    checkOutput("swap_image_num", bus_a.image_num_core, tag);
    checkOutput("core_start_t1", bus_a.core_start, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("core_start_t2", bus_a.core_start, 1);
    checkOutput("busy_run", bus_a.busy, 1);
  endtask

  task automatic streamPixels(input int n, input bit with_last, input int wfd_at);
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == wfd_at, 4'hF, 1, with_last && (i == n - 1), 0, 0);
    end
  endtask

  task automatic finishFrame(input logic [3:0] cls, input logic [3:0] tag, input logic wfd,
                             input int exp_frames);
    result_t r;
    r.cls = cls;
    r.tag = tag;
    exp_q.push_back(r);
    applyStimulus(wfd, 4'hE, 0, 0, 1, cls);
    checkOutput("result_valid", bus_a.result_valid, 1);
    checkOutput("result_class", bus_a.result_class, cls);
    checkOutput("result_tag", bus_a.result_tag, tag);
    checkOutput("frame_cnt", bus_a.frame_cnt, exp_frames);
    checkOutput("busy_done", bus_a.busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("result_valid_once", bus_a.result_valid, 0);
  endtask

  // One camera frame on dut_b; if it is accepted, run a 1-pixel frame to completion.
  task automatic stepB();
    bus_b.wr_frame_done = 1'b1;
    tick();
    bus_b.wr_frame_done = 1'b0;
    if (bus_b.busy) begin
      tick();
      bus_b.q_valid      = 1'b1;
      bus_b.q_frame_last = 1'b1;
      tick();
      bus_b.q_valid      = 1'b0;
      bus_b.q_frame_last = 1'b0;
      tick();
      bus_b.cnn_done = 1'b1;
      tick();
      bus_b.cnn_done = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic resetB();
    srst_b = 1'b1;
    tick();
    tick();
    srst_b = 1'b0;
  endtask

  initial begin
    srst_a = 1'b1;
    srst_b = 1'b1;
    bus_a.wr_frame_done = 0; bus_a.image_num_in = 0; bus_a.q_valid = 0;
    bus_a.q_frame_last = 0; bus_a.cnn_ready = 1; bus_a.cnn_done = 0; bus_a.cnn_class = 0;
    bus_b.wr_frame_done = 0; bus_b.image_num_in = 4'h2; bus_b.q_valid = 0;
    bus_b.q_frame_last = 0; bus_b.cnn_ready = 1; bus_b.cnn_done = 0; bus_b.cnn_class = 4'h1;
    resetA();
    resetB();

    $display("[TB] reset state");
    checkOutput("rst_wr_bank", bus_a.wr_bank, 0);
    checkOutput("rst_rd_bank", bus_a.rd_bank, 1);
    checkOutput("rst_busy", bus_a.busy, 0);
    checkOutput("rst_frame_cnt", bus_a.frame_cnt, 0);
    checkOutput("rst_drop_cnt", bus_a.drop_cnt, 0);
    checkOutput("rst_len_err", bus_a.len_err, 0);
    checkOutput("rst_wdog_err", bus_a.wdog_err, 0);
    checkOutput("rst_result_class", bus_a.result_class, 0);
    checkOutput("rst_result_tag", bus_a.result_tag, 0);
    checkOutput("rst_image_num", bus_a.image_num_core, 0);
    checkOutput("rst_pulses", {bus_a.core_start, bus_a.cnn_start, bus_a.result_valid}, 0);

    $display("[TB] nominal frame");
    startFrame(4'd5, 1'b1);
    streamPixels(FRAME_PIX, 1, -1);
    checkOutput("cnn_start_kick", bus_a.cnn_start, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("cnn_start_once", bus_a.cnn_start, 0);
    checkOutput("busy_cnn", bus_a.busy, 1);
    finishFrame(4'd7, 4'd5, 1'b0, 1);
    checkOutput("nominal_len_err", bus_a.len_err, 0);
    checkOutput("nominal_core_starts", core_start_a, 1);
    checkOutput("nominal_cnn_starts", cnn_start_a, 1);

    $display("[TB] length error");
    resetA();
    startFrame(4'd6, 1'b1);
    streamPixels(1000, 1, -1);
    checkOutput("len_err_set", bus_a.len_err, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    finishFrame(4'd3, 4'd6, 1'b0, 1);

    $display("[TB] busy drops");
    snap = core_start_a;
    startFrame(4'd9, 1'b0);
    streamPixels(FRAME_PIX, 1, 10);
    checkOutput("drop_in_run", bus_a.drop_cnt, 1);
    checkOutput("drop_run_wr_bank", bus_a.wr_bank, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'hB, 0, 0, 0, 0);
    checkOutput("drop_in_cnn", bus_a.drop_cnt, 2);
    checkOutput("drop_cnn_wr_bank", bus_a.wr_bank, 0);
    finishFrame(4'd2, 4'd9, 1'b0, 2);
    checkOutput("drop_core_starts", core_start_a - snap, 1);
    checkOutput("len_err_sticky", bus_a.len_err, 1);

    $display("[TB] cnn_done with simultaneous frame");
    startFrame(4'd10, 1'b1);
    streamPixels(FRAME_PIX, 1, -1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    finishFrame(4'd4, 4'd10, 1'b1, 3);
    checkOutput("simul_drop_cnt", bus_a.drop_cnt, 3);
    checkOutput("simul_wr_bank", bus_a.wr_bank, 1);
    checkOutput("simul_no_restart", bus_a.busy, 0);

    $display("[TB] reset mid-frame");
    resetA();
    startFrame(4'd3, 1'b1);
    streamPixels(500, 0, -1);
    snap = core_start_a + cnn_start_a + result_a;
    srst_a = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    srst_a = 1'b0;
    checkOutput("mid_rst_wr_bank", bus_a.wr_bank, 0);
    checkOutput("mid_rst_rd_bank", bus_a.rd_bank, 1);
    checkOutput("mid_rst_busy", bus_a.busy, 0);
    checkOutput("mid_rst_counters", {bus_a.frame_cnt, bus_a.drop_cnt}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_no_pulses", core_start_a + cnn_start_a + result_a - snap, 0);
    startFrame(4'd4, 1'b1);

    $display("[TB] decimation by 3, ready");
    resetB();
    bus_b.cnn_ready = 1'b1;
    stepB();
    stepB();
    checkOutput("div_no_start_yet", core_start_b, 0);
    stepB();
    checkOutput("div_start_on_3rd", core_start_b, 1);
    stepB();
    stepB();
    stepB();
    checkOutput("div_starts", core_start_b, 2);
    checkOutput("div_drop_cnt", bus_b.drop_cnt, 0);
    checkOutput("div_frame_cnt", bus_b.frame_cnt, 2);

    $display("[TB] decimation by 3, not ready");
    resetB();
    bus_b.cnn_ready = 1'b0;
    snap = core_start_b;
    for (int i = 0; i < 6; i++) stepB();
    checkOutput("notready_starts", core_start_b - snap, 0);
    checkOutput("notready_drop_cnt", bus_b.drop_cnt, 2);

    $display("[TB] CNN stall");
    resetB();
    bus_b.cnn_ready = 1'b1;
    stepB();
    stepB();
    bus_b.wr_frame_done = 1'b1;
    tick();
    bus_b.wr_frame_done = 1'b0;
    tick();
    bus_b.q_valid      = 1'b1;
    bus_b.q_frame_last = 1'b1;
    tick();
    bus_b.q_valid      = 1'b0;
    bus_b.q_frame_last = 1'b0;
    tick();
    snap = result_b;
    for (int i = 0; i < 99; i++) tick();
    checkOutput("stall_wdog_early", bus_b.wdog_err, 0);
    checkOutput("stall_busy_early", bus_b.busy, 1);
`ifdef FRAME_SCHED_WDOG_EN
    tick();
    checkOutput("wdog_err_set", bus_b.wdog_err, 1);
    checkOutput("wdog_busy", bus_b.busy, 0);
    checkOutput("wdog_drop_cnt", bus_b.drop_cnt, 1);
    tick();
    checkOutput("wdog_no_result", result_b - snap, 0);
    checkOutput("wdog_frame_cnt", bus_b.frame_cnt, 0);
`else
    for (int i = 0; i < 51; i++) tick();
    checkOutput("nowdog_err", bus_b.wdog_err, 0);
    checkOutput("nowdog_busy", bus_b.busy, 1);
    checkOutput("nowdog_no_result", result_b - snap, 0);
    bus_b.cnn_done = 1'b1;
    tick();
    bus_b.cnn_done = 1'b0;
    checkOutput("nowdog_result", bus_b.result_valid, 1);
    checkOutput("nowdog_busy_done", bus_b.busy, 0);
`endif

    tick();
    checkOutput("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/frame_sched_ctrl.md
Name: frame_sched_ctrl

Overview:
- Frame-level scheduler for the capture → MaxPool/Pad/Quantize → LeNet path.
- Owns the ping-pong frame BRAM bank selection and issues the 1-clk `start` to the core reader.
- Checks the length of the 32x32 s8 processed stream, then starts the LeNet accelerator and latches its classification result.
- Sits between the camera BRAM writer, the core top and the CNN engine. Frames arriving while the pipeline is busy are dropped and counted.

Parameters:
- FRAME_PIX, 1024, expected processed pixels per frame (32x32).
- FRAME_DIV, 1, process every FRAME_DIV-th completed camera frame (1 = all); must be ≥1.
- CW, 16, width of frame/drop counters (saturating).
- WDOG_CYC, 400000, watchdog limit in clk cycles for RUN and CNN states (used only with FRAME_SCHED_WDOG_EN).

Ports:
- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- wr_frame_done  in  1  1-clk pulse: camera writer finished filling bank wr_bank
- image_num_in  in  4  tag of the frame just written
- q_valid  in  1  processed-stream valid from core
- q_frame_last  in  1  last processed pixel of frame
- cnn_ready  in  1  accelerator input buffer free
- cnn_done  in  1  1-clk pulse: classification finished
- cnn_class  in  4  class index, valid with cnn_done
- wr_bank  out  1  bank the writer fills
- rd_bank  out  1  bank the core reads (always ~wr_bank)
- core_start  out  1  1-clk pulse to core `start`
- image_num_core  out  4  tag of frame in flight
- cnn_start  out  1  1-clk pulse to accelerator
- result_valid  out  1  1-clk pulse, result latched
- result_class  out  4  last class
- result_tag  out  4  image tag of result
- busy  out  1  state != IDLE
- frame_cnt  out  CW  frames fully classified
- drop_cnt  out  CW  frames dropped (busy or not ready)
- len_err  out  1  sticky, processed length mismatch
- wdog_err  out  1  sticky, watchdog fired (0 when feature off)

Behaviour:
- Reset values: state IDLE; wr_bank=0, rd_bank=1; all pulses 0; result_class, result_tag, image_num_core = 0; counters 0; len_err=0, wdog_err=0; internal divider counter 0. All outputs are registered.
- States: IDLE, SWAP, RUN, KICK, CNN.
- IDLE, on wr_frame_done (at cycle t):
  - div_cnt = FRAME_DIV-1 (or FRAME_DIV=1) and cnn_ready=1: at t+1 swap wr_bank/rd_bank, latch image_num_core=image_num_in, reset div_cnt to 0, go to SWAP.
  - div_cnt = FRAME_DIV-1 and cnn_ready=0: drop_cnt += 1, div_cnt → 0, stay IDLE.
  - Otherwise: div_cnt += 1, stay IDLE. Decimated frames are not drops.
- SWAP: core_start=1 for exactly this one cycle (t+2), pixel count pc cleared, go to RUN. Start-to-swap latency is fixed at 2 clk.
- RUN:
  - Each q_valid increments pc (11 bit, saturating at 2047).
  - On q_valid && q_frame_last: if pc+1 != FRAME_PIX, set len_err. Go to KICK.
- KICK: cnn_start=1 for one cycle, go to CNN.
- CNN: on cnn_done, latch result_class=cnn_class and result_tag=image_num_core, result_valid=1 next cycle, frame_cnt += 1, go to IDLE.
- wr_frame_done in any state other than IDLE: drop_cnt += 1, no bank swap. The writer keeps its bank and overwrites it. div_cnt is unchanged.
- Simultaneous events:
  - cnn_done and wr_frame_done in the same cycle: the result completes; the frame is counted as dropped.
  - In IDLE the new frame is evaluated only from the next cycle.
- q_valid outside RUN is ignored. q_frame_last without q_valid is ignored.
- Counters saturate at 2^CW-1, with no wrap.
- srst mid-frame: immediate return to reset values, including banks. No pulse is emitted in the reset cycle or the cycle after.

Optional Feature:
- FRAME_SCHED_WDOG_EN defined:
  - A cycle counter runs in RUN and CNN and clears on each state entry.
  - Reaching WDOG_CYC sets wdog_err (sticky), increments drop_cnt, and returns to IDLE without cnn_start or result_valid.
- Undefined: no counter is instantiated, wdog_err is tied 0, and RUN/CNN wait indefinitely.

Decomposition:
- Package lenet_pipe_pkg:
  - constants OUT_W=32, OUT_H_PAD=32, FRAME_PIX=1024;
  - state encoding localparams S_IDLE..S_CNN;
  - tag width 4; class width 4.
- One natural sub-module: sat_counter (parameter W, inc, clear → saturating count), reused for frame_cnt, drop_cnt and the watchdog.

Test Plan:
- Nominal flow: FRAME_DIV=1, cnn_ready=1; wr_frame_done with tag 5 at t → banks swap at t+1 (wr_bank=1), core_start at t+2. Then feed 1024 q_valid with q_frame_last on the last → cnn_start 1 clk later. cnn_done with class 7 → result_valid, result_class=7, result_tag=5, frame_cnt=1, len_err=0.
- Length error: 1000 pixels, then q_frame_last → len_err=1 sticky; flow still completes, frame_cnt=1.
- Busy drop: second wr_frame_done during RUN and another during CNN → drop_cnt=2; wr_bank unchanged; no extra core_start.
- Decimation and not-ready drop:
  - FRAME_DIV=3, 6 wr_frame_done pulses spaced while idle → exactly 2 core_start pulses (on 3rd and 6th), drop_cnt=0.
  - Repeat with cnn_ready=0 → 0 starts, drop_cnt=2.
- Reset mid-frame: srst during RUN at pixel 500 → wr_bank=0, rd_bank=1, busy=0, counters 0. Next wr_frame_done yields a normal 2-clk core_start.
- Watchdog: with FRAME_SCHED_WDOG_EN and WDOG_CYC=100, stall in CNN (no cnn_done) → wdog_err=1 at cycle 100, drop_cnt+1, busy=0, no result_valid. Without the macro → stays in CNN, wdog_err=0.
